// File: rtl/wb_jtag_driver.sv
// Wishbone-controlled JTAG initiator: runs IR/DR scans and TAP resets through
// a divided TCK and captures TDO into a readable register.
module wb_jtag_driver #(
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_RST   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] clkdiv_q, clkdiv_d;
    logic [4:0]  step_q, step_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] tdi_reg_q, tdi_reg_d;
    logic [31:0] tdo_q, tdo_d;
    logic [31:0] dat_q, dat_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        ir_q, ir_d;
    logic        done_q, done_d;
    logic        ien_q, ien_d;
    logic        irq_q, irq_d;
    logic        ack_q, ack_d;

    logic        bus_req_s;
    logic        wr_s;
    logic        busy_s;
    logic        wrap_s;
    logic        tck_rise_s;
    logic        tck_fall_s;
    logic [1:0]  reg_sel_s;
    logic [4:0]  step_inc_s;
    logic [4:0]  hdr_last_s;
    logic        unused_s;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign unused_s = ^wb_adr_i[1:0];

    // Decode of the bus request and divider/scan status.
    always_comb begin
        bus_req_s  = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_s       = bus_req_s & wb_we_i;
        reg_sel_s  = wb_adr_i[3:2];
        busy_s     = (state_q != ST_IDLE);
        wrap_s     = busy_s & (div_cnt_q == clkdiv_q);
        tck_rise_s = wrap_s & ~tck_q;
        tck_fall_s = wrap_s & tck_q;
        step_inc_s = step_q + 5'd1;
        hdr_last_s = ir_q ? 5'd3 : 5'd2;
    end

    // Next-state logic: register access, scan launch and the TCK-driven FSM.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        clkdiv_d  = clkdiv_q;
        step_d    = step_q;
        len_d     = len_q;
        tdi_reg_d = tdi_reg_q;
        tdo_d     = tdo_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        ir_d      = ir_q;
        done_d    = done_q;
        ien_d     = ien_q;
        ack_d     = bus_req_s;
        irq_d     = done_q & ien_q;

        if (bus_req_s && !wb_we_i) begin
            case (reg_sel_s)
                2'd0:    dat_d = {19'd0, len_q, 4'd0, ien_q, done_q, ir_q, busy_s};
                2'd1:    dat_d = tdi_reg_q;
                2'd2:    dat_d = tdo_q;
                2'd3:    dat_d = {16'd0, clkdiv_q};
                default: dat_d = 32'd0;
            endcase
        end else begin
            dat_d = 32'd0;
        end

        if (wr_s) begin
            case (reg_sel_s)
                2'd0: begin
                    ien_d = wb_dat_i[3];
                    if (wb_dat_i[2]) begin
                        done_d = 1'b0;
                    end else begin
                        done_d = done_q;
                    end
                    if (!busy_s) begin
                        ir_d  = wb_dat_i[1];
                        len_d = wb_dat_i[12:8];
                        // TAP reset takes priority over a scan request.
                        if (wb_dat_i[4]) begin
                            state_d   = ST_RST;
                            step_d    = 5'd0;
                            tms_d     = 1'b1;
                            tck_d     = 1'b0;
                            div_cnt_d = 16'd0;
                        end else if (wb_dat_i[0]) begin
                            state_d   = ST_HDR;
                            step_d    = 5'd0;
                            tms_d     = 1'b1;
                            tck_d     = 1'b0;
                            div_cnt_d = 16'd0;
                            done_d    = 1'b0;
                            tdo_d     = 32'd0;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        ir_d = ir_q;
                    end
                end
                2'd1: begin
                    if (!busy_s) begin
                        tdi_reg_d = be_merge(tdi_reg_q, wb_dat_i, wb_sel_i);
                    end else begin
                        tdi_reg_d = tdi_reg_q;
                    end
                end
                2'd3: begin
                    if (!busy_s) begin
                        clkdiv_d[7:0]  = wb_sel_i[0] ? wb_dat_i[7:0]  : clkdiv_q[7:0];
                        clkdiv_d[15:8] = wb_sel_i[1] ? wb_dat_i[15:8] : clkdiv_q[15:8];
                    end else begin
                        clkdiv_d = clkdiv_q;
                    end
                end
                default: begin
                    tdo_d = tdo_q;
                end
            endcase
        end else begin
            ack_d = bus_req_s;
        end

        // TMS/TDI advance only on falling TCK; TDO is sampled on rising TCK.
        if (busy_s) begin
            if (wrap_s) begin
                div_cnt_d = 16'd0;
                tck_d     = ~tck_q;
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
                tck_d     = tck_q;
            end
            if (tck_rise_s && (state_q == ST_SHIFT)) begin
                tdo_d[step_q] = tdo_i;
            end else begin
                tdo_d = tdo_q;
            end
            if (tck_fall_s) begin
                case (state_q)
                    ST_HDR: begin
                        if (step_q == hdr_last_s) begin
                            state_d = ST_SHIFT;
                            step_d  = 5'd0;
                            tms_d   = (len_q == 5'd0);
                            tdi_d   = tdi_reg_q[0];
                        end else begin
                            step_d = step_inc_s;
                            tms_d  = ir_q & (step_inc_s == 5'd1);
                        end
                    end
                    ST_SHIFT: begin
                        if (step_q == len_q) begin
                            state_d = ST_TAIL;
                            step_d  = 5'd0;
                            tms_d   = 1'b1;
                        end else begin
                            step_d = step_inc_s;
                            tdi_d  = tdi_reg_q[step_inc_s];
                            tms_d  = (step_inc_s == len_q);
                        end
                    end
                    ST_TAIL: begin
                        if (step_q == 5'd0) begin
                            step_d = 5'd1;
                            tms_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = 5'd0;
                            tms_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                    ST_RST: begin
                        if (step_q == 5'd5) begin
                            state_d = ST_IDLE;
                            step_d  = 5'd0;
                            tms_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            step_d = step_inc_s;
                            tms_d  = (step_inc_s != 5'd5);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        tms_d   = 1'b0;
                    end
                endcase
            end else begin
                step_d = step_d;
            end
        end else begin
            div_cnt_d = 16'd0;
            tck_d     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= 16'd0;
            clkdiv_q  <= DEFAULT_DIV;
            step_q    <= 5'd0;
            len_q     <= 5'd0;
            tdi_reg_q <= 32'd0;
            tdo_q     <= 32'd0;
            dat_q     <= 32'd0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            ir_q      <= 1'b0;
            done_q    <= 1'b0;
            ien_q     <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            clkdiv_q  <= clkdiv_d;
            step_q    <= step_d;
            len_q     <= len_d;
            tdi_reg_q <= tdi_reg_d;
            tdo_q     <= tdo_d;
            dat_q     <= dat_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            ien_q     <= ien_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign irq_o    = irq_q;
    assign tck_o    = tck_q;
    assign tms_o    = tms_q;
    assign tdi_o    = tdi_q;

endmodule
